// File: rtl/esn_y_history.sv
// esn_y_history: multi-channel ESN output register with a per-channel
// circular history of the last DEPTH samples. All channels share one
// write pointer, one fill counter and one read delay.
module esn_y_history #(
  parameter int                    BIT_LENGTH  = 32,
  parameter int                    NUM_CH      = 1,
  parameter int                    DEPTH       = 8,
  parameter int                    ADDR_LENGTH = $clog2(DEPTH),
  parameter logic [BIT_LENGTH-1:0] INIT_VALUE  = 32'hbebc24da
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*BIT_LENGTH-1:0] y_i,
  input  logic                         EN_wr_n,
  input  logic                         clr,
  input  logic                         EN_rd_n,
  input  logic [ADDR_LENGTH-1:0]       rd_delay,
  output logic [NUM_CH*BIT_LENGTH-1:0] y_last_o,
  output logic [NUM_CH*BIT_LENGTH-1:0] y_hist_o,
  output logic                         rd_valid,
  output logic                         rd_oor,
  output logic [ADDR_LENGTH:0]         fill_cnt,
  output logic                         full
);

  localparam int                     W        = NUM_CH * BIT_LENGTH;
  localparam logic [W-1:0]           INIT_ALL = {NUM_CH{INIT_VALUE}};
  localparam logic [ADDR_LENGTH:0]   DEPTH_C  = (ADDR_LENGTH+1)'(DEPTH);
  localparam logic [ADDR_LENGTH:0]   ONE_C    = (ADDR_LENGTH+1)'(1);
  localparam logic [ADDR_LENGTH-1:0] LAST_PTR = ADDR_LENGTH'(DEPTH - 1);

  logic [W-1:0]           mem_q [DEPTH];
  logic [ADDR_LENGTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LENGTH:0]   fill_q, fill_d;
  logic                   full_q, full_d;
  logic [W-1:0]           last_q, last_d;
  logic [W-1:0]           hist_q, hist_d;
  logic                   valid_q, valid_d;
  logic                   oor_q, oor_d;

  logic                   wr_en_s, rd_en_s, oor_s;
  logic [ADDR_LENGTH:0]   dly_s, rd_sum_s, rd_idx_s;

  assign wr_en_s = ~EN_wr_n;
  assign rd_en_s = ~EN_rd_n;

  // Read address: (wr_ptr - 1 - k) mod DEPTH without relying on a power-of-two wrap.
  always_comb begin
    oor_s = ({1'b0, rd_delay} >= DEPTH_C);
    if (oor_s) begin
      dly_s = '0;
    end else begin
      dly_s = {1'b0, rd_delay};
    end
    // Biasing by DEPTH keeps the sum non-negative; one conditional subtract folds it back.
    rd_sum_s = {1'b0, wr_ptr_q} + DEPTH_C - ONE_C - dly_s;
    if (rd_sum_s >= DEPTH_C) begin
      rd_idx_s = rd_sum_s - DEPTH_C;
    end else begin
      rd_idx_s = rd_sum_s;
    end
  end

  // Next-state for pointer, fill level, newest sample and read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    full_d   = full_q;
    last_d   = last_q;
    hist_d   = hist_q;
    valid_d  = 1'b0;
    oor_d    = oor_q;

    // clr wins over a same-cycle write.
    if (clr) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      full_d   = 1'b0;
      last_d   = INIT_ALL;
    end else if (wr_en_s) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (fill_q >= DEPTH_C) begin
        fill_d = DEPTH_C;
      end else begin
        fill_d = fill_q + ONE_C;
      end
      full_d = (fill_q >= (DEPTH_C - ONE_C));
      last_d = y_i;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Reads see pre-write / pre-clear contents: mem_q is the registered array.
    if (rd_en_s) begin
      valid_d = 1'b1;
      oor_d   = oor_s;
      if (oor_s) begin
        hist_d = INIT_ALL;
      end else begin
        hist_d = mem_q[rd_idx_s[ADDR_LENGTH-1:0]];
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      last_q   <= INIT_ALL;
      hist_q   <= INIT_ALL;
      valid_q  <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      last_q   <= last_d;
      hist_q   <= hist_d;
      valid_q  <= valid_d;
      oor_q    <= oor_d;
    end
  end

  // History storage: seeded with INIT_VALUE, one entry written per accepted write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_ALL;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_ALL;
    end else if (wr_en_s) begin
      mem_q[wr_ptr_q] <= y_i;
    end
  end

  assign y_last_o = last_q;
  assign y_hist_o = hist_q;
  assign rd_valid = valid_q;
  assign rd_oor   = oor_q;
  assign fill_cnt = fill_q;
  assign full     = full_q;

endmodule

// File: tb/tb_esn_y_history.sv
// Bench for esn_y_history: two instances (DEPTH=4 and DEPTH=5, NUM_CH=2)
// driven by the same stimulus, each compared with an age-ordered history model.
module tb_esn_y_history;

  localparam logic [63:0] INIT = {2{32'hbebc24da}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] y_i = '0;
  logic        EN_wr_n = 1'b1;
  logic        clr = 1'b0;
  logic        EN_rd_n = 1'b1;
  logic [2:0]  rd_delay = '0;

  logic [63:0] last0, last1, hist0, hist1;
  logic        val0, val1, oor0, oor1, full0, full1;
  logic [3:0]  fill0, fill1;

  esn_y_history #(.BIT_LENGTH(32), .NUM_CH(2), .DEPTH(4), .ADDR_LENGTH(3)) dut4 (
    .clk(clk), .rst(rst), .y_i(y_i), .EN_wr_n(EN_wr_n), .clr(clr),
    .EN_rd_n(EN_rd_n), .rd_delay(rd_delay), .y_last_o(last0), .y_hist_o(hist0),
    .rd_valid(val0), .rd_oor(oor0), .fill_cnt(fill0), .full(full0));

  esn_y_history #(.BIT_LENGTH(32), .NUM_CH(2), .DEPTH(5)) dut5 (
    .clk(clk), .rst(rst), .y_i(y_i), .EN_wr_n(EN_wr_n), .clr(clr),
    .EN_rd_n(EN_rd_n), .rd_delay(rd_delay), .y_last_o(last1), .y_hist_o(hist1),
    .rd_valid(val1), .rd_oor(oor1), .fill_cnt(fill1), .full(full1));

  always #5 clk = ~clk;

  // Model: hist[u][a] is the sample written a writes ago (a=0 newest).
  logic [63:0] m_hist [2][8];
  int          m_cnt  [2];
  logic [63:0] m_last [2];
  logic [63:0] m_out  [2];
  logic        m_val  [2];
  logic        m_oor  [2];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  function automatic int dep(input int u);
    return (u == 0) ? 4 : 5;
  endfunction

  task automatic chk(input string tag, input int u, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s[D%0d] observed=%h expected=%h", tag, dep(u), obs, exp);
    end
  endtask

  task automatic check_all();
    chk("y_last", 0, last0, m_last[0]);
    chk("y_last", 1, last1, m_last[1]);
    chk("y_hist", 0, hist0, m_out[0]);
    chk("y_hist", 1, hist1, m_out[1]);
    chk("rd_valid", 0, 64'(val0), 64'(m_val[0]));
    chk("rd_valid", 1, 64'(val1), 64'(m_val[1]));
    chk("rd_oor", 0, 64'(oor0), 64'(m_oor[0]));
    chk("rd_oor", 1, 64'(oor1), 64'(m_oor[1]));
    chk("fill_cnt", 0, 64'(fill0), 64'(m_cnt[0]));
    chk("fill_cnt", 1, 64'(fill1), 64'(m_cnt[1]));
    chk("full", 0, 64'(full0), 64'(m_cnt[0] == dep(0)));
    chk("full", 1, 64'(full1), 64'(m_cnt[1] == dep(1)));
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 8; a++) m_hist[u][a] = INIT;
      m_cnt[u] = 0; m_last[u] = INIT; m_out[u] = INIT; m_val[u] = 1'b0; m_oor[u] = 1'b0;
    end
  endtask

  // One clock cycle with the given controls; model updated from pre-edge state.
  task automatic cyc(input bit wr, input logic [63:0] y, input bit rd, input int k, input bit c);
    y_i = y; EN_wr_n = ~wr; EN_rd_n = ~rd; rd_delay = 3'(k); clr = c;
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      m_val[u] = rd;
      if (rd) begin
        m_oor[u] = (k >= dep(u));
        if (k >= dep(u) || k >= m_cnt[u]) m_out[u] = INIT;
        else m_out[u] = m_hist[u][k];
      end
      if (c) begin
        for (int a = 0; a < 8; a++) m_hist[u][a] = INIT;
        m_cnt[u] = 0; m_last[u] = INIT;
      end else if (wr) begin
        for (int a = 7; a > 0; a--) m_hist[u][a] = m_hist[u][a-1];
        m_hist[u][0] = y;
        if (m_cnt[u] < dep(u)) m_cnt[u]++;
        m_last[u] = y;
      end
    end
    #1;
    check_all();
    EN_wr_n = 1'b1; EN_rd_n = 1'b1; clr = 1'b0;
  endtask

  // Reset asserted mid-cycle while a read request is set up for the next edge.
  task automatic rst_pulse_during_read(input int k);
    EN_rd_n = 1'b0; rd_delay = 3'(k);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    EN_rd_n = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all();
    cyc(0, '0, 0, 0, 0);
  endtask

  logic [63:0] a_s, b_s, c_s, w_s, x_s;

  initial begin
    model_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    check_all();

    // Write A,B,C then read k=0..3.
    a_s = {$urandom, $urandom}; b_s = {$urandom, $urandom}; c_s = {$urandom, $urandom};
    cyc(1, a_s, 0, 0, 0);
    cyc(1, b_s, 0, 0, 0);
    cyc(1, c_s, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, k, 0);

    // Async reset mid-cycle.
    rst_pulse_during_read(0);

    // Wrap: 1..6 then k=0..3; then clear and 1..7 then k=4.
    for (int i = 1; i <= 6; i++) cyc(1, {2{32'(i)}}, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, '0, 1, k, 0);
    cyc(0, '0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) cyc(1, {2{32'(i)}}, 0, 0, 0);
    cyc(0, '0, 1, 4, 0);

    // Same-cycle write X and read k=0 after W.
    w_s = {$urandom, $urandom}; x_s = {$urandom, $urandom};
    cyc(1, w_s, 0, 0, 0);
    cyc(1, x_s, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);

    // Out-of-range delay, then a normal read clears rd_oor.
    cyc(0, '0, 1, 7, 0);
    cyc(0, '0, 1, 5, 0);
    cyc(0, '0, 1, 0, 0);

    // clr with write and read in the same cycle, then inspect.
    cyc(1, {$urandom, $urandom}, 1, 1, 1);
    for (int k = 0; k < 3; k++) cyc(0, '0, 1, k, 0);
    rst_pulse_during_read(1);

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      cyc(bit'($urandom_range(0, 1)), {$urandom, $urandom}, bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
